// File: rtl/tx_ds_se.sv
// tx_ds_se: single-ended Data-Strobe line encoder, transmit side.
// Ports: TxClk, TxReset (sync, active-high), Tx1/Tx0 one-hot bit request,
//   D/S registered line outputs, TxErr sticky collision flag
//   (only with TX_DS_SE_COLLISION_EN defined).
module tx_ds_se (
  input  logic TxClk,
  input  logic TxReset,
  input  logic Tx1,
  input  logic Tx0,
  output logic D,
  output logic S
`ifdef TX_DS_SE_COLLISION_EN
  ,
  output logic TxErr
`endif
);

  logic send;
  logic par;

  // exactly one request line high means a bit goes out;
  // both high is a collision and is treated as idle
  assign send = Tx1 ^ Tx0;
  assign par  = D ^ S;

  // the new strobe is chosen so D^S toggles once per bit
  always_ff @(posedge TxClk) begin
    if (TxReset) begin
      D <= 1'b0;
      S <= 1'b0;
    end else if (send) begin
      D <= Tx1;
      S <= Tx1 ^ ~par;
    end
  end

`ifdef TX_DS_SE_COLLISION_EN
  always_ff @(posedge TxClk) begin
    if (TxReset)
      TxErr <= 1'b0;
    else if (Tx1 && Tx0)
      TxErr <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_tx_ds_se.sv
// tb_tx_ds_se: vector table plus randomized run against a
// bit-count parity model of the DS encoder.
module tb_tx_ds_se;

  logic clk = 1'b0;
  logic rst;
  logic t1;
  logic t0;
  logic d;
  logic s;
  logic err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

`ifdef TX_DS_SE_COLLISION_EN
  tx_ds_se dut (
    .TxClk(clk), .TxReset(rst), .Tx1(t1), .Tx0(t0),
    .D(d), .S(s), .TxErr(err)
  );
`else
  tx_ds_se dut (
    .TxClk(clk), .TxReset(rst), .Tx1(t1), .Tx0(t0),
    .D(d), .S(s)
  );
  assign err = 1'b0;
`endif

  typedef struct {
    logic rst;
    logic t1;
    logic t0;
    logic ed;
    logic es;
    logic ee;
  } vec_t;

  vec_t tbl[$];

  // model: D is the last bit sent, parity is bit count mod 2
  logic m_last;
  logic m_cnt;
  logic m_err;

  task automatic chk(input string nm, input logic [2:0] act,
                     input logic [2:0] exp, input bit use_err);
    n_cmp++;
    if (!use_err) begin
      act[0] = 1'b0;
      exp[0] = 1'b0;
    end
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got D,S,Err=%b required %b at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic a,
                              input logic b, input logic ed,
                              input logic es, input logic ee);
    vec_t v;
    v.rst = r; v.t1 = a; v.t0 = b;
    v.ed = ed; v.es = es; v.ee = ee;
    return v;
  endfunction

  bit use_err;

  initial begin
`ifdef TX_DS_SE_COLLISION_EN
    use_err = 1'b1;
`else
    use_err = 1'b0;
`endif
    // reset then idle
    tbl.push_back(mk(1,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0));
    // run of ones, then reset with Tx1 still high
    tbl.push_back(mk(0,1,0, 1,0,0));
    tbl.push_back(mk(0,1,0, 1,1,0));
    tbl.push_back(mk(0,1,0, 1,0,0));
    tbl.push_back(mk(1,1,0, 0,0,0));
    // run of zeros
    tbl.push_back(mk(0,0,1, 0,1,0));
    tbl.push_back(mk(0,0,1, 0,0,0));
    // mixed 0,1,0
    tbl.push_back(mk(1,0,0, 0,0,0));
    tbl.push_back(mk(0,0,1, 0,1,0));
    tbl.push_back(mk(0,1,0, 1,1,0));
    tbl.push_back(mk(0,0,1, 0,1,0));
    // mixed 1,0
    tbl.push_back(mk(1,0,0, 0,0,0));
    tbl.push_back(mk(0,1,0, 1,0,0));
    tbl.push_back(mk(0,0,1, 0,0,0));
    // mixed 1,1,0
    tbl.push_back(mk(1,0,0, 0,0,0));
    tbl.push_back(mk(0,1,0, 1,0,0));
    tbl.push_back(mk(0,1,0, 1,1,0));
    tbl.push_back(mk(0,0,1, 0,1,0));
    // back to (1,1), idle hold, then a one
    tbl.push_back(mk(0,1,0, 1,1,0));
    tbl.push_back(mk(0,0,0, 1,1,0));
    tbl.push_back(mk(0,0,0, 1,1,0));
    tbl.push_back(mk(0,0,0, 1,1,0));
    tbl.push_back(mk(0,1,0, 1,0,0));
    // collision from (1,0): hold, sticky error
    tbl.push_back(mk(0,1,1, 1,0,1));
    tbl.push_back(mk(0,0,0, 1,0,1));
    tbl.push_back(mk(0,1,0, 1,1,1));
    tbl.push_back(mk(1,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0, 0,0,0));

    rst = 1'b0; t1 = 1'b0; t0 = 1'b0;
    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      t1  = tbl[i].t1;
      t0  = tbl[i].t0;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), {d, s, err},
          {tbl[i].ed, tbl[i].es, tbl[i].ee}, use_err);
    end

    // randomized run, starting from a reset
    rst = 1'b1; t1 = 1'b0; t0 = 1'b0;
    @(posedge clk);
    #1;
    m_last = 1'b0; m_cnt = 1'b0; m_err = 1'b0;
    chk("rand_reset", {d, s, err}, {m_last, m_last ^ m_cnt, m_err},
        use_err);
    for (int k = 0; k < 2000; k++) begin
      rst = ($urandom_range(0, 31) == 0);
      t1  = $urandom_range(0, 1);
      t0  = $urandom_range(0, 1);
      #1;
      // inputs must not reach the outputs before the edge
      chk("no_comb", {d, s, err}, {m_last, m_last ^ m_cnt, m_err},
          use_err);
      if (rst) begin
        m_last = 1'b0; m_cnt = 1'b0; m_err = 1'b0;
      end else if (t1 != t0) begin
        m_last = t1;
        m_cnt  = ~m_cnt;
      end else if (t1 && t0) begin
        m_err = 1'b1;
      end
      @(posedge clk);
      #1;
      chk($sformatf("rand%0d", k), {d, s, err},
          {m_last, m_last ^ m_cnt, m_err}, use_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
